// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load/store unit types, funct3 codes and alignment helpers
package lsu_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } ld_state_e;

    // Only the low address bits matter for alignment, so callers pass addr[1:0].
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] funct3);
        logic mis;
        mis = 1'b0;
        case (funct3)
            LD_LH, LD_LHU: mis = addr_lo[0];
            LD_LW:         mis = (addr_lo != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic illegal_ld_funct3(input logic [2:0] funct3);
        return !(funct3 inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU});
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and sign/zero-extends the addressed byte/halfword of a word
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (i_lane)
            2'd0:    byte_sel = i_word[7:0];
            2'd1:    byte_sel = i_word[15:8];
            2'd2:    byte_sel = i_word[23:16];
            default: byte_sel = i_word[31:24];
        endcase
        half_sel = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_funct3)
            LD_LB:   o_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LH:   o_data = {{16{half_sel[15]}}, half_sel};
            LD_LW:   o_data = i_word;
            LD_LBU:  o_data = {24'd0, byte_sel};
            LD_LHU:  o_data = {16'd0, half_sel};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - multi-cycle load unit with req/ack memory read port and timeout
module load_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [31:0] i_ld_addr,
    input  logic [2:0]  i_ld_funct3,
    output logic        o_ld_done,
    output logic [31:0] o_ld_data,
    output logic        o_ld_err,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    ld_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] aligned;

    // Formatting is applied to the raw word on ack and the result registered,
    // so o_ld_data never depends combinationally on i_mem_rdata.
    load_align u_align (
        .i_word   (i_mem_rdata),
        .i_lane   (addr_q[1:0]),
        .i_funct3 (funct3_q),
        .o_data   (aligned)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            cnt_q    <= '0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (i_ld_valid) begin
                    addr_d   = i_ld_addr;
                    funct3_d = i_ld_funct3;
                    cnt_d    = '0;
                    if (illegal_ld_funct3(i_ld_funct3) || misaligned(i_ld_addr[1:0], i_ld_funct3)) begin
                        state_d = ERR;
                        data_d  = 32'd0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // An ack in the limit cycle takes priority over the timeout.
                if (i_mem_ack) begin
                    data_d  = aligned;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = 32'd0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_ld_ready = (state_q == IDLE);
    assign o_mem_req  = (state_q == REQ);
    assign o_ld_done  = (state_q == DONE) || (state_q == ERR);
    assign o_ld_err   = (state_q == ERR);
    assign o_ld_data  = data_q;
    assign o_mem_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - self-checking bench for load_unit
module tb_load_unit;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_ld_valid = 1'b0;
    logic        o_ld_ready;
    logic [31:0] i_ld_addr = 32'd0;
    logic [2:0]  i_ld_funct3 = 3'd0;
    logic        o_ld_done;
    logic [31:0] o_ld_data;
    logic        o_ld_err;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;

    int tests = 0;
    int fails = 0;

    load_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ld_valid  (i_ld_valid),
        .o_ld_ready  (o_ld_ready),
        .i_ld_addr   (i_ld_addr),
        .i_ld_funct3 (i_ld_funct3),
        .o_ld_done   (o_ld_done),
        .o_ld_data   (o_ld_data),
        .o_ld_err    (o_ld_err),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          waits;
        bit          ack_en;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_req;
    } vec_t;

    vec_t vecs[14];

    // One load: accept, drive ack after `waits` extra REQ cycles, check timing and result.
    task automatic run_load(input int id, input vec_t v);
        int req_cyc = 0;
        int lat = 0;
        int mism = 0;
        bit seen = 1'b0;
        logic [31:0] d = 32'd0;
        logic e = 1'b0;
        @(negedge i_clk);
        check($sformatf("v%0d_ready_before", id), {31'd0, o_ld_ready}, 32'd1);
        i_ld_valid  = 1'b1;
        i_ld_addr   = v.addr;
        i_ld_funct3 = v.f3;
        @(negedge i_clk);
        i_ld_valid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (c > 0) @(negedge i_clk);
            lat = c + 1;
            i_mem_ack = 1'b0;
            if (o_mem_req) begin
                req_cyc++;
                if (o_mem_addr !== {v.addr[31:2], 2'b00}) mism++;
                if (v.ack_en && req_cyc == v.waits + 1) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = v.rdata;
                end
            end
            if (o_ld_done) begin
                seen = 1'b1;
                d = o_ld_data;
                e = o_ld_err;
                if (o_ld_ready) mism++;
            end
        end
        i_mem_ack = 1'b0;
        check($sformatf("v%0d_done_seen", id), {31'd0, seen}, 32'd1);
        check($sformatf("v%0d_latency", id), lat, v.exp_req + 1);
        check($sformatf("v%0d_req_cycles", id), req_cyc, v.exp_req);
        check($sformatf("v%0d_addr_ready_mism", id), mism, 0);
        check($sformatf("v%0d_err", id), {31'd0, e}, {31'd0, v.exp_err});
        check($sformatf("v%0d_data", id), d, v.exp_data);
        @(negedge i_clk);
        check($sformatf("v%0d_done_pulse", id), {31'd0, o_ld_done}, 32'd0);
        check($sformatf("v%0d_ready_after", id), {31'd0, o_ld_ready}, 32'd1);
        check($sformatf("v%0d_data_hold", id), o_ld_data, v.exp_data);
    endtask

    initial begin
        int dones;
        int done_cyc[2];
        logic [31:0] done_dat[2];
        int c;

        // LB/LBU/LHU/LH on rdata 0x80FF_1234
        vecs[0]  = '{3'b000, 32'h0000_0203, 32'h80FF_1234, 0, 1'b1, 32'hFFFF_FF80, 1'b0, 1};
        vecs[1]  = '{3'b100, 32'h0000_0202, 32'h80FF_1234, 0, 1'b1, 32'h0000_00FF, 1'b0, 1};
        vecs[2]  = '{3'b101, 32'h0000_0202, 32'h80FF_1234, 0, 1'b1, 32'h0000_80FF, 1'b0, 1};
        vecs[3]  = '{3'b001, 32'h0000_0200, 32'h80FF_1234, 0, 1'b1, 32'h0000_1234, 1'b0, 1};
        vecs[4]  = '{3'b001, 32'h0000_0202, 32'h80FF_1234, 0, 1'b1, 32'hFFFF_80FF, 1'b0, 1};
        vecs[5]  = '{3'b000, 32'h0000_0201, 32'h80FF_1234, 1, 1'b1, 32'h0000_0012, 1'b0, 2};
        vecs[6]  = '{3'b100, 32'h0000_0203, 32'h80FF_1234, 2, 1'b1, 32'h0000_0080, 1'b0, 3};
        // Misaligned and illegal: immediate error, no memory request
        vecs[7]  = '{3'b010, 32'h0000_0102, 32'h1111_1111, 0, 1'b1, 32'h0000_0000, 1'b1, 0};
        vecs[8]  = '{3'b001, 32'h0000_0101, 32'h1111_1111, 0, 1'b1, 32'h0000_0000, 1'b1, 0};
        vecs[9]  = '{3'b011, 32'h0000_0100, 32'h1111_1111, 0, 1'b1, 32'h0000_0000, 1'b1, 0};
        vecs[10] = '{3'b111, 32'h0000_0100, 32'h1111_1111, 0, 1'b1, 32'h0000_0000, 1'b1, 0};
        // Ack in the limit cycle wins; then a true timeout
        vecs[11] = '{3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, 4};
        vecs[12] = '{3'b010, 32'h0000_0400, 32'h2222_2222, 0, 1'b0, 32'h0000_0000, 1'b1, 4};
        vecs[13] = '{3'b101, 32'h0000_0301, 32'h3333_3333, 0, 1'b1, 32'h0000_0000, 1'b1, 0};

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_ready", {31'd0, o_ld_ready}, 32'd1);
        check("rst_done", {31'd0, o_ld_done}, 32'd0);
        check("rst_err", {31'd0, o_ld_err}, 32'd0);
        check("rst_data", o_ld_data, 32'd0);
        check("rst_req", {31'd0, o_mem_req}, 32'd0);
        check("rst_maddr", o_mem_addr, 32'd0);
        i_rst = 1'b1;

        for (int i = 0; i < 14; i++) run_load(i, vecs[i]);

        // Reset mid-REQ: LW at 0x100, never acked
        @(negedge i_clk);
        i_ld_valid  = 1'b1;
        i_ld_addr   = 32'h0000_0100;
        i_ld_funct3 = 3'b010;
        @(negedge i_clk);
        i_ld_valid = 1'b0;
        check("mid_req_up", {31'd0, o_mem_req}, 32'd1);
        check("mid_req_addr", o_mem_addr, 32'h0000_0100);
        repeat (2) @(negedge i_clk);
        check("mid_req_still", {31'd0, o_mem_req}, 32'd1);
        #2 i_rst = 1'b0;
        #1;
        check("mid_req_async_drop", {31'd0, o_mem_req}, 32'd0);
        check("mid_req_async_done", {31'd0, o_ld_done}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (o_ld_done || o_mem_req || !o_ld_ready) dones++;
        end
        check("mid_req_quiet_after", dones, 0);

        // Stray ack in IDLE
        @(negedge i_clk);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hBAD0_BAD0;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        check("stray_ack_req", {31'd0, o_mem_req}, 32'd0);
        check("stray_ack_done", {31'd0, o_ld_done}, 32'd0);
        check("stray_ack_ready", {31'd0, o_ld_ready}, 32'd1);

        // Back-to-back LW with valid held continuously
        i_ld_valid  = 1'b1;
        i_ld_addr   = 32'h0000_0500;
        i_ld_funct3 = 3'b010;
        dones = 0;
        c = 0;
        while (dones < 2 && c < 30) begin
            if (c > 0) @(negedge i_clk);
            i_mem_ack = 1'b0;
            if (o_mem_req) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = (o_mem_addr == 32'h0000_0500) ? 32'hA5A5_0001 : 32'h5A5A_0002;
            end
            if (o_ld_done) begin
                done_cyc[dones] = c;
                done_dat[dones] = o_ld_data;
                dones++;
                i_ld_addr = 32'h0000_0504;
            end
            c++;
        end
        i_ld_valid = 1'b0;
        i_mem_ack  = 1'b0;
        check("b2b_two_dones", dones, 2);
        if (dones == 2) begin
            check("b2b_done1_cycle", done_cyc[0], 2);
            check("b2b_done2_cycle", done_cyc[1], 5);
            check("b2b_data1", done_dat[0], 32'hA5A5_0001);
            check("b2b_data2", done_dat[1], 32'h5A5A_0002);
        end
        @(negedge i_clk);
        check("b2b_idle_after", {31'd0, o_ld_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
